// File: rtl/bitstream_integrator_multi_if.sv
// Bus bundle for bitstream_integrator_multi: per-channel bitstreams in, packed results out.
interface bitstream_integrator_multi_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16
);
  logic [CHANNELS-1:0]       x;
  logic                      capture;
  logic                      start;
  logic                      mode;
  logic                      bipolar;
  logic [CHANNELS*WIDTH-1:0] y;
  logic                      valid;
  logic                      busy;

  modport master (
    output x, capture, start, mode, bipolar,
    input  y, valid, busy
  );

  modport slave (
    input  x, capture, start, mode, bipolar,
    output y, valid, busy
  );
endinterface

// File: rtl/bitstream_integrator_multi.sv
// Counts ones (unipolar) or signed +/-1 (bipolar) per channel over an external or
// internally timed window, with per-channel saturation and a registered result.
module bitstream_integrator_multi #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned WINDOW   = 256
) (
  input logic                          clk,
  input logic                          rst,
  bitstream_integrator_multi_if.slave  bus
);
  localparam int unsigned CntW = $clog2(WINDOW + 1);
  localparam logic [WIDTH-1:0] UMax = '1;
  localparam logic [WIDTH-1:0] SMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMin = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StReading, StOutput} state_e;

  state_e                             state_q, state_d;
  logic [CHANNELS-1:0][WIDTH-1:0]     acc_q, acc_d;
  logic [CHANNELS-1:0][WIDTH-1:0]     y_q, y_d;
  logic [CntW-1:0]                    cnt_q, cnt_d;
  logic                               cfg_mode_q, cfg_mode_d;
  logic                               cfg_bip_q, cfg_bip_d;
  logic                               valid_q, valid_d;
  logic                               trigger;

  function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] a, input logic b,
                                                input logic bip);
    logic [WIDTH-1:0] r;
    r = a;
    if (!bip) begin
      if (b && a != UMax) r = a + WIDTH'(1);
    end else if (b) begin
      if (a != SMax) r = a + WIDTH'(1);
    end else begin
      if (a != SMin) r = a - WIDTH'(1);
    end
    return r;
  endfunction

  // Trigger follows the live mode input; the run itself uses the latched copy.
  assign trigger = bus.mode ? bus.start : bus.capture;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    cfg_mode_d = cfg_mode_q;
    cfg_bip_d  = cfg_bip_q;
    valid_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          acc_d      = '0;
          cnt_d      = '0;
          cfg_mode_d = bus.mode;
          cfg_bip_d  = bus.bipolar;
          state_d    = StReading;
        end
      end
      StReading: begin
        for (int i = 0; i < CHANNELS; i++) begin
          acc_d[i] = sat_step(acc_q[i], bus.x[i], cfg_bip_q);
        end
        if (cfg_mode_q) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WINDOW - 1)) state_d = StOutput;
        end else if (!bus.capture) begin
          state_d = StOutput;
        end
      end
      StOutput: begin
        y_d     = acc_q;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      y_q        <= '0;
      cnt_q      <= '0;
      cfg_mode_q <= 1'b0;
      cfg_bip_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      cfg_mode_q <= cfg_mode_d;
      cfg_bip_q  <= cfg_bip_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.y     = y_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state_q != StIdle);
endmodule

// File: tb/tb_bitstream_integrator_multi.sv
// Directed bench: window modes, bipolar, external gate, saturation and mid-run reset.
module tb_bitstream_integrator_multi;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  bitstream_integrator_multi_if #(.CHANNELS(4), .WIDTH(16)) ifa ();
  bitstream_integrator_multi_if #(.CHANNELS(4), .WIDTH(4))  ifb ();

  bitstream_integrator_multi #(.CHANNELS(4), .WIDTH(16), .WINDOW(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  bitstream_integrator_multi #(.CHANNELS(4), .WIDTH(4), .WINDOW(20)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 8-cycle window on dut_a; flip toggles bipolar mid-run, which must not matter.
  task automatic run_a(input logic bip, input logic flip, input logic [15:0] e0,
                       input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
    logic [3:0] k4;
    ifa.mode    = 1'b1;
    ifa.bipolar = bip;
    ifa.start   = 1'b1;
    ifa.x       = 4'b0000;
    tick();
    check("a_busy_run", {15'd0, ifa.busy}, 16'd1);
    ifa.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      k4 = 4'(k);
      ifa.x = {(k == 3), 1'b0, k4[0], 1'b1};
      if (flip && k == 4) ifa.bipolar = ~bip;
      tick();
    end
    check("a_valid_early", {15'd0, ifa.valid}, 16'd0);
    tick();
    check("a_valid", {15'd0, ifa.valid}, 16'd1);
    check("a_busy_done", {15'd0, ifa.busy}, 16'd0);
    check("a_ch0", ifa.y[15:0], e0);
    check("a_ch1", ifa.y[31:16], e1);
    check("a_ch2", ifa.y[47:32], e2);
    check("a_ch3", ifa.y[63:48], e3);
    ifa.bipolar = 1'b0;
    tick();
    check("a_valid_once", {15'd0, ifa.valid}, 16'd0);
  endtask

  task automatic run_b(input logic bip, input logic [3:0] xv, input logic [3:0] e);
    ifb.mode    = 1'b1;
    ifb.bipolar = bip;
    ifb.start   = 1'b1;
    ifb.x       = xv;
    tick();
    ifb.start = 1'b0;
    repeat (20) tick();
    check("b_valid_early", {15'd0, ifb.valid}, 16'd0);
    tick();
    check("b_valid", {15'd0, ifb.valid}, 16'd1);
    check("b_ch0", {12'd0, ifb.y[3:0]}, {12'd0, e});
    check("b_ch3", {12'd0, ifb.y[15:12]}, {12'd0, e});
    tick();
  endtask

  initial begin
    int vcount;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ifa.x = '0; ifa.capture = 1'b0; ifa.start = 1'b0; ifa.mode = 1'b0; ifa.bipolar = 1'b0;
    ifb.x = '0; ifb.capture = 1'b0; ifb.start = 1'b0; ifb.mode = 1'b0; ifb.bipolar = 1'b0;
    tick();
    tick();
    check("rst_y", ifa.y[15:0], 16'd0);
    check("rst_valid", {15'd0, ifa.valid}, 16'd0);
    check("rst_busy", {15'd0, ifa.busy}, 16'd0);
    rst = 1'b0;
    tick();

    run_a(1'b0, 1'b0, 16'd8, 16'd4, 16'd0, 16'd1);
    run_a(1'b1, 1'b0, 16'd8, 16'd0, 16'hFFF8, 16'hFFFA);

    // External gate: capture on edges 0..5, low on edge 6 -> 6 samples.
    ifa.mode    = 1'b0;
    ifa.bipolar = 1'b0;
    ifa.x       = 4'b0001;
    ifa.capture = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      ifa.start = (k == 2);
      ifa.mode  = (k == 2);
      tick();
    end
    ifa.start   = 1'b0;
    ifa.mode    = 1'b0;
    ifa.capture = 1'b0;
    tick();
    check("g_valid_early", {15'd0, ifa.valid}, 16'd0);
    check("g_busy", {15'd0, ifa.busy}, 16'd1);
    tick();
    check("g_valid", {15'd0, ifa.valid}, 16'd1);
    check("g_ch0", ifa.y[15:0], 16'd6);
    check("g_ch1", ifa.y[31:16], 16'd0);
    tick();
    check("g_idle", {15'd0, ifa.busy}, 16'd0);

    run_b(1'b0, 4'b1111, 4'hF);
    run_b(1'b1, 4'b0000, 4'h8);
    run_b(1'b1, 4'b1111, 4'h7);

    // Reset on READING edge 4 discards the partial window.
    ifa.mode  = 1'b1;
    ifa.start = 1'b1;
    ifa.x     = 4'b1111;
    tick();
    ifa.start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("mr_busy", {15'd0, ifa.busy}, 16'd0);
    check("mr_valid", {15'd0, ifa.valid}, 16'd0);
    check("mr_y", ifa.y[15:0], 16'd0);
    tick();
    rst    = 1'b0;
    vcount = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ifa.valid === 1'b1) vcount++;
    end
    check("mr_no_valid", 16'(vcount), 16'd0);
    run_a(1'b0, 1'b1, 16'd8, 16'd4, 16'd0, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
